accel_sha_round_ctrl: RTL and testbench
=======================================

Name: accel_sha_round_ctrl

Overview:
Sequencing controller for the optimized SHA-256 compressor/scheduler pair. It accepts a multi-block hash job, drives the compressor's update_A_H, update_H0_7, rst_hash_n, is_hashing and round index i, and handshakes with the message-block buffer and word scheduler. One instance per hash lane; double-SHA256 is two back-to-back jobs issued by the top-level miner FSM.

Parameters:
ROUNDS, 64, compression rounds per 512-bit block
BLK_W, 4, width of block count/index (max 15 blocks per job)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  job request; accepted only in IDLE
num_blocks  input  BLK_W  512-bit blocks in job; sampled with accepted start
abort  input  1  synchronous job cancel
blk_req  output  1  request next message block from buffer
blk_valid  input  1  buffer has presented the requested block to the scheduler
w_valid  input  1  scheduler word w valid this cycle
w_rd  output  1  consume current scheduler word
update_A_H  output  1  compressor A–H register update strobe
update_H0_7  output  1  compressor H0–H7 accumulate strobe
rst_hash_n  output  1  active-low reinit of H0–H7 to SHA-256 IV
is_hashing  output  1  compressor in round mode (low = A–H load from H0–H7)
i  output  7  current round index 0..ROUNDS-1
blk_idx  output  BLK_W  index of block being processed
busy  output  1  high in every state except IDLE
done  output  1  one-cycle job-complete pulse; cm_out valid in that cycle

Behaviour:
- Clock and reset: one clock clk; reset rst_n synchronous, active-low. While rst_n=0 at an edge: state=IDLE, i=0, blk_idx=0, blocks latch=0.
- Moore outputs decoded from registered state. Reset/IDLE values: busy=0, done=0, blk_req=0, w_rd=0, update_A_H=0, update_H0_7=0, rst_hash_n=1, is_hashing=0, i=0, blk_idx=0.
- States: IDLE, INIT, WAIT_BLK, LOAD, ROUND, FINAL, DONE.
- IDLE: start=1 and num_blocks!=0 -> INIT, latch num_blocks, blk_idx=0. start with num_blocks=0 ignored (stay IDLE, no done). start outside IDLE ignored.
- INIT (1 cycle): rst_hash_n=0 -> WAIT_BLK.
- WAIT_BLK: blk_req=1; held until blk_valid=1 -> LOAD. blk_valid outside WAIT_BLK ignored.
- LOAD (1 cycle): update_A_H=1, is_hashing=0 (A–H <= H0–H7); i=0 -> ROUND.
- ROUND: is_hashing=1. update_A_H = w_rd = w_valid. On w_valid: i<=i+1, except i==ROUNDS-1 -> FINAL and i<=0. On w_valid=0: stall, i held, no strobes. i never exceeds ROUNDS-1.
- FINAL (1 cycle): update_H0_7=1, is_hashing=0. If blk_idx==num_blocks-1 -> DONE; else blk_idx+1 -> WAIT_BLK.
- DONE (1 cycle): done=1, busy=1 -> IDLE. A start in this cycle is ignored; a new start is accepted from IDLE the following cycle.
- abort=1 in any non-IDLE state -> IDLE next cycle, i=0, blk_idx=0, no done, no further strobes. abort takes priority over all other transitions including DONE. abort in IDLE has no effect.
- Reset mid-job: identical to abort; compressor state is not cleaned up because next job begins with INIT.
- Latency, 1 block, blk_valid and w_valid constantly 1: start accepted at edge T; INIT cycle T+1, WAIT_BLK T+2, LOAD T+3, ROUND T+4..T+67, FINAL T+68, done high cycle T+69. Each additional block adds 67 cycles (WAIT_BLK + LOAD + 64 ROUND + FINAL).
- Exactly ROUNDS update_A_H pulses with is_hashing=1 per block, plus one LOAD pulse.

Decomposition:
- Package accel_sha_pkg: state enum typedef sha_ctrl_state_t, localparam SHA_ROUNDS=64, SHA_IDX_W=7.
- Round counter with stall/terminal flag as sub-module accel_round_cnt (en, clr, i, last). All remaining logic lives in one FSM module.

Test Plan:
- Reset then start, num_blocks=1, blk_valid/w_valid tied 1 -> rst_hash_n low only at T+1; 65 update_A_H pulses (1 with is_hashing=0); update_H0_7 at T+68; done at T+69; busy low T+70.
- num_blocks=2, blk_valid delayed 5 cycles on block 1 -> blk_req held 6 cycles; blk_idx=1 in second pass; exactly two update_H0_7 pulses; done at T+69+67+5.
- w_valid low for cycles with i=10..12 -> i holds at 10, no update_A_H or w_rd during stall; total 64 round strobes; done delayed by 3 cycles.
- abort asserted at i=30 -> IDLE next cycle, busy=0, done never pulses; new start with num_blocks=1 completes normally with rst_hash_n pulse.
- start with num_blocks=0 -> remains IDLE, busy=0; start in ROUND and DONE -> ignored, no extra blk_req.
- rst_n=0 for one cycle mid-FINAL -> all outputs at reset values next cycle, no update_H0_7 afterward.

Source files
------------

// File: rtl/accel_sha_pkg.sv
// rtl/accel_sha_pkg.sv - shared types and constants for the SHA-256 round sequencer
package accel_sha_pkg;

  localparam int SHA_ROUNDS = 64;
  localparam int SHA_IDX_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_LOAD     = 3'd3,
    ST_ROUND    = 3'd4,
    ST_FINAL    = 3'd5,
    ST_DONE     = 3'd6
  } sha_ctrl_state_t;

endpackage

// File: rtl/accel_round_cnt.sv
// rtl/accel_round_cnt.sv - stallable round index counter with terminal flag
module accel_round_cnt
  import accel_sha_pkg::*;
#(
  parameter int ROUNDS = SHA_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  output logic [SHA_IDX_W-1:0] i,
  output logic                 last
);

  logic [SHA_IDX_W-1:0] r_i;

  assign i    = r_i;
  assign last = (r_i == SHA_IDX_W'(ROUNDS - 1));

  // Advance on each consumed word; wrap to 0 after the final round so the index never exceeds ROUNDS-1.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_i <= '0;
    end else if (en) begin
      r_i <= last ? '0 : r_i + 1'b1;
    end
  end

endmodule

// File: rtl/accel_sha_round_ctrl.sv
// rtl/accel_sha_round_ctrl.sv - job sequencer for the SHA-256 compressor/scheduler pair
module accel_sha_round_ctrl
  import accel_sha_pkg::*;
#(
  parameter int ROUNDS = SHA_ROUNDS,
  parameter int BLK_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BLK_W-1:0]     num_blocks,
  input  logic                 abort,
  output logic                 blk_req,
  input  logic                 blk_valid,
  input  logic                 w_valid,
  output logic                 w_rd,
  output logic                 update_A_H,
  output logic                 update_H0_7,
  output logic                 rst_hash_n,
  output logic                 is_hashing,
  output logic [SHA_IDX_W-1:0] i,
  output logic [BLK_W-1:0]     blk_idx,
  output logic                 busy,
  output logic                 done
);

  sha_ctrl_state_t      r_state;
  sha_ctrl_state_t      w_next_state;
  logic [BLK_W-1:0]     r_num_blocks;
  logic [BLK_W-1:0]     r_blk_idx;
  logic                 w_accept;
  logic                 w_blk_adv;
  logic                 w_cnt_en;
  logic                 w_cnt_clr;
  logic                 w_last;
  logic [SHA_IDX_W-1:0] w_i;

  assign i       = w_i;
  assign blk_idx = r_blk_idx;

  accel_round_cnt #(
    .ROUNDS (ROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_cnt_en),
    .clr   (w_cnt_clr),
    .i     (w_i),
    .last  (w_last)
  );

  // State register; reset mid-job simply drops back to IDLE since the next job re-inits the compressor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Job length latch and block index; index returns to 0 whenever the FSM heads back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_num_blocks <= '0;
      r_blk_idx    <= '0;
    end else if (w_accept) begin
      r_num_blocks <= num_blocks;
      r_blk_idx    <= '0;
    end else if (w_next_state == ST_IDLE) begin
      r_blk_idx    <= '0;
    end else if (w_blk_adv) begin
      r_blk_idx    <= r_blk_idx + 1'b1;
    end
  end

  // Next-state and strobe decode; only the ROUND strobes follow w_valid so stalls emit nothing.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    blk_req      = 1'b0;
    w_rd         = 1'b0;
    update_A_H   = 1'b0;
    update_H0_7  = 1'b0;
    rst_hash_n   = 1'b1;
    is_hashing   = 1'b0;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_accept     = 1'b0;
    w_blk_adv    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && (num_blocks != '0)) begin
          w_accept     = 1'b1;
          w_next_state = ST_INIT;
        end
      end
      ST_INIT: begin
        rst_hash_n   = 1'b0;
        w_next_state = ST_WAIT_BLK;
      end
      ST_WAIT_BLK: begin
        blk_req = 1'b1;
        if (blk_valid) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        update_A_H   = 1'b1;
        w_cnt_clr    = 1'b1;
        w_next_state = ST_ROUND;
      end
      ST_ROUND: begin
        is_hashing = 1'b1;
        update_A_H = w_valid;
        w_rd       = w_valid;
        w_cnt_en   = w_valid;
        if (w_valid && w_last) begin
          w_next_state = ST_FINAL;
        end
      end
      ST_FINAL: begin
        update_H0_7 = 1'b1;
        if (r_blk_idx == (r_num_blocks - 1'b1)) begin
          w_next_state = ST_DONE;
        end else begin
          w_blk_adv    = 1'b1;
          w_next_state = ST_WAIT_BLK;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Cancel outranks every other transition, including completion.
    if (abort && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_cnt_clr    = 1'b1;
      w_cnt_en     = 1'b0;
      w_blk_adv    = 1'b0;
    end
  end

endmodule

// File: tb/tb_accel_sha_round_ctrl.sv
// tb/tb_accel_sha_round_ctrl.sv - scoreboard bench for the SHA-256 round sequencer
module tb_accel_sha_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_blocks = 4'd0;
  logic       abort = 1'b0;
  logic       blk_valid = 1'b0;
  logic       w_valid = 1'b0;
  logic       blk_req, w_rd, update_A_H, update_H0_7, rst_hash_n, is_hashing, busy, done;
  logic [6:0] i;
  logic [3:0] blk_idx;

  typedef struct {
    int lat;
    int n_round;
    int n_load;
    int n_h07;
    int n_req;
    int n_rst;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int blk_delay[16];
  int req_cnt    = 0;
  int stall_at   = -1;
  int stall_left = 0;

  int init_cyc = 0, last_done_cyc = 0;
  int m_round = 0, m_load = 0, m_h07 = 0, m_req = 0, m_rst = 0, m_wrd = 0;
  logic prev_rst_hash_n = 1'b1;

  accel_sha_round_ctrl #(.ROUNDS(64), .BLK_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_blocks  (num_blocks),
    .abort       (abort),
    .blk_req     (blk_req),
    .blk_valid   (blk_valid),
    .w_valid     (w_valid),
    .w_rd        (w_rd),
    .update_A_H  (update_A_H),
    .update_H0_7 (update_H0_7),
    .rst_hash_n  (rst_hash_n),
    .is_hashing  (is_hashing),
    .i           (i),
    .blk_idx     (blk_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block buffer and scheduler models: blk_valid after a per-block delay, w_valid with an optional stall.
  always @(posedge clk) begin
    #1;
    if (blk_req === 1'b1) begin
      req_cnt   = req_cnt + 1;
      blk_valid = (req_cnt > blk_delay[blk_idx]);
    end else begin
      req_cnt   = 0;
      blk_valid = 1'b0;
    end
    if (is_hashing === 1'b1 && int'(i) == stall_at && stall_left > 0) begin
      w_valid    = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      w_valid = 1'b1;
    end
  end

  // Job monitor: counts strobes since the last rst_hash_n pulse and scores them when done fires.
  always @(negedge clk) begin
    if (rst_hash_n === 1'b0 && prev_rst_hash_n === 1'b1) begin
      init_cyc = cyc;
      m_round = 0; m_load = 0; m_h07 = 0; m_req = 0; m_rst = 0; m_wrd = 0;
    end
    prev_rst_hash_n = rst_hash_n;
    if (rst_hash_n === 1'b0) m_rst++;
    if (update_A_H === 1'b1 && is_hashing === 1'b1) m_round++;
    if (update_A_H === 1'b1 && is_hashing === 1'b0) m_load++;
    if (update_H0_7 === 1'b1) m_h07++;
    if (blk_req === 1'b1) m_req++;
    if (w_rd === 1'b1) m_wrd++;
    if (done === 1'b1) begin
      exp_t e;
      last_done_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        if ((cyc - init_cyc) !== e.lat) begin
          n_fail++;
          $display("FAIL latency: got %0d required %0d", cyc - init_cyc, e.lat);
        end
        n_tests++;
        if (m_round !== e.n_round) begin
          n_fail++;
          $display("FAIL round_strobes: got %0d required %0d", m_round, e.n_round);
        end
        n_tests++;
        if (m_load !== e.n_load) begin
          n_fail++;
          $display("FAIL load_strobes: got %0d required %0d", m_load, e.n_load);
        end
        n_tests++;
        if (m_h07 !== e.n_h07) begin
          n_fail++;
          $display("FAIL h07_strobes: got %0d required %0d", m_h07, e.n_h07);
        end
        n_tests++;
        if (m_req !== e.n_req) begin
          n_fail++;
          $display("FAIL blk_req_cycles: got %0d required %0d", m_req, e.n_req);
        end
        n_tests++;
        if (m_rst !== e.n_rst) begin
          n_fail++;
          $display("FAIL rst_hash_cycles: got %0d required %0d", m_rst, e.n_rst);
        end
        n_tests++;
        if (m_wrd !== e.n_round) begin
          n_fail++;
          $display("FAIL w_rd_count: got %0d required %0d", m_wrd, e.n_round);
        end
      end
    end
  end

  task automatic start_job(input logic [3:0] nb);
    @(posedge clk); #1;
    start = 1'b1;
    num_blocks = nb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, blk_req, w_rd, update_A_H, update_H0_7, rst_hash_n, is_hashing} !== 8'b0000_0010) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000010",
               {busy, done, blk_req, w_rd, update_A_H, update_H0_7, rst_hash_n, is_hashing});
    end
    n_tests++;
    if (i !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_i: got %0d required 0", i);
    end
    n_tests++;
    if (blk_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_blk_idx: got %0d required 0", blk_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_block;
    bit ok;
    exp_q.push_back('{lat: 68, n_round: 64, n_load: 1, n_h07: 1, n_req: 1, n_rst: 1});
    start_job(4'd1);
    wait_idle(200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: got busy=%b required 0 within 200 cycles", busy);
    end
    n_tests++;
    if ((cyc - last_done_cyc) !== 1) begin
      n_fail++;
      $display("FAIL single_busy_drop: got %0d cycles after done required 1", cyc - last_done_cyc);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_pending: got %0d queued required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_multi_block;
    int idx_seen[$];
    bit ok;
    ok = 1'b0;
    blk_delay[1] = 5;
    exp_q.push_back('{lat: 140, n_round: 128, n_load: 2, n_h07: 2, n_req: 7, n_rst: 1});
    start_job(4'd2);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (update_H0_7 === 1'b1) idx_seen.push_back(int'(blk_idx));
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    blk_delay[1] = 0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL multi_timeout: got busy=%b required 0 within 400 cycles", busy);
    end
    n_tests++;
    if (idx_seen.size() !== 2) begin
      n_fail++;
      $display("FAIL multi_h07_count: got %0d required 2", idx_seen.size());
    end else begin
      n_tests++;
      if (idx_seen[0] !== 0 || idx_seen[1] !== 1) begin
        n_fail++;
        $display("FAIL multi_blk_idx: got %0d,%0d required 0,1", idx_seen[0], idx_seen[1]);
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL multi_pending: got %0d queued required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall;
    int n_stall;
    bit ok;
    n_stall = 0;
    ok = 1'b0;
    stall_at = 10;
    stall_left = 3;
    exp_q.push_back('{lat: 71, n_round: 64, n_load: 1, n_h07: 1, n_req: 1, n_rst: 1});
    start_job(4'd1);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (is_hashing === 1'b1 && w_valid === 1'b0) begin
        n_stall++;
        n_tests++;
        if (i !== 7'd10 || update_A_H !== 1'b0 || w_rd !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold: got i=%0d upd=%b w_rd=%b required i=10 upd=0 w_rd=0", i, update_A_H, w_rd);
        end
      end
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    stall_at = -1;
    n_tests++;
    if (!ok || n_stall !== 3) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d (idle=%0d) required 3", n_stall, ok);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_pending: got %0d queued required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort;
    bit found, ok;
    int bad;
    found = 1'b0;
    bad = 0;
    start_job(4'd1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (is_hashing === 1'b1 && i === 7'd30) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach_i30: got i=%0d required 30", i);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || i !== 7'd0 || blk_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b i=%0d blk_idx=%0d required 0 0 0", busy, i, blk_idx);
    end
    repeat (80) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || update_A_H !== 1'b0 || update_H0_7 !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", bad);
    end
    exp_q.push_back('{lat: 68, n_round: 64, n_load: 1, n_h07: 1, n_req: 1, n_rst: 1});
    start_job(4'd1);
    wait_idle(200, ok);
    n_tests++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_restart: got idle=%0d queued=%0d required 1 0", ok, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ignored_starts;
    int bad;
    bit found;
    bad = 0;
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    num_blocks = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || rst_hash_n !== 1'b1 || blk_req !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL zero_blocks: got %0d active cycles required 0", bad);
    end
    exp_q.push_back('{lat: 68, n_round: 64, n_load: 1, n_h07: 1, n_req: 1, n_rst: 1});
    start_job(4'd1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (is_hashing === 1'b1 && i === 7'd20) break;
    end
    start = 1'b1;
    num_blocks = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    start = 1'b1;
    num_blocks = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || blk_req !== 1'b0) bad++;
    end
    n_tests++;
    if (!found || bad !== 0) begin
      n_fail++;
      $display("FAIL start_in_done: got done_seen=%0d active=%0d required 1 0", found, bad);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ignored_pending: got %0d queued required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_final;
    int bad;
    bit found;
    bad = 0;
    found = 1'b0;
    start_job(4'd1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (update_H0_7 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if (!found || {busy, done, blk_req, w_rd, update_A_H, update_H0_7, rst_hash_n, is_hashing} !== 8'b0000_0010
        || i !== 7'd0 || blk_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_final: got flags=%b i=%0d blk_idx=%0d final_seen=%0d required 00000010 0 0 1",
               {busy, done, blk_req, w_rd, update_A_H, update_H0_7, rst_hash_n, is_hashing}, i, blk_idx, found);
    end
    repeat (80) begin
      @(negedge clk);
      if (update_H0_7 !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) blk_delay[k] = 0;
    test_reset();
    test_single_block();
    test_multi_block();
    test_stall();
    test_abort();
    test_ignored_starts();
    test_reset_mid_final();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d queued required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
